dcache_ctrl: RTL and testbench



---
 rtl/dcache_ctrl.sv | 147 ++++++++++++++
 tb/tb_dcache_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate L1 data cache controller
module dcache_ctrl #(
  parameter int LINES      = 32,
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [ADDR_W-1:0]          cpu_addr_i,
  input  logic [31:0]                cpu_data_i,
  input  logic                       cpu_MemRd_i,
  input  logic                       cpu_MemWr_i,
  output logic [31:0]                cpu_data_o,
  output logic                       cpu_stall_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  output logic [32*LINE_WORDS-1:0]   mem_data_o,
  output logic                       mem_enable_o,
  output logic                       mem_write_o,
  input  logic [32*LINE_WORDS-1:0]   mem_data_i,
  input  logic                       mem_ack_i
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_t;

  state_t state_q, state_d;

  logic [LINES-1:0]                  valid_q;
  logic [LINES-1:0]                  dirty_q;
  logic [TAG_W-1:0]                  tag_q  [LINES];
  logic [LINE_WORDS-1:0][31:0]       data_q [LINES];
  logic [IDX_W-1:0]                  miss_idx_q;
  logic [TAG_W-1:0]                  miss_tag_q;

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             req;
  logic             hit;
  logic             write_hit;
  logic             alloc_done;
  logic             unused_byte_bits;

  assign req_off          = cpu_addr_i[OFF_W+1:2];
  assign req_idx          = cpu_addr_i[IDX_W+OFF_W+1:OFF_W+2];
  assign req_tag          = cpu_addr_i[ADDR_W-1:ADDR_W-TAG_W];
  assign unused_byte_bits = ^cpu_addr_i[1:0];

  assign req        = cpu_MemRd_i | cpu_MemWr_i;
  assign hit        = req & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  // A store wins when both controls are high, so any MemWr hit is a write.
  assign write_hit  = (state_q == IDLE) & hit & cpu_MemWr_i;
  assign alloc_done = (state_q == ALLOCATE) & mem_ack_i;

  // State, line status bits and the latched miss target; reset drops everything in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req && !hit) begin
        miss_idx_q <= req_idx;
        miss_tag_q <= req_tag;
      end
      if (write_hit) begin
        dirty_q[req_idx] <= 1'b1;
      end
      if (alloc_done) begin
        valid_q[miss_idx_q] <= 1'b1;
        dirty_q[miss_idx_q] <= 1'b0;
      end
    end
  end

  // Tag and data arrays are never cleared; they only change on store hits and refills.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (write_hit) begin
        data_q[req_idx][req_off] <= cpu_data_i;
      end
      if (alloc_done) begin
        data_q[miss_idx_q] <= mem_data_i;
        tag_q[miss_idx_q]  <= miss_tag_q;
      end
    end
  end

  // Next state and all outputs; outputs forced quiet while reset is asserted.
  always_comb begin
    state_d      = state_q;
    cpu_stall_o  = 1'b0;
    cpu_data_o   = '0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          if (req) begin
            if (hit) begin
              if (!cpu_MemWr_i) begin
                cpu_data_o = data_q[req_idx][req_off];
              end
            end else begin
              cpu_stall_o = 1'b1;
              state_d     = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          cpu_stall_o  = 1'b1;
          mem_enable_o = 1'b1;
          mem_write_o  = 1'b1;
          mem_addr_o   = {tag_q[miss_idx_q], miss_idx_q, {(OFF_W+2){1'b0}}};
          mem_data_o   = data_q[miss_idx_q];
          if (mem_ack_i) begin
            state_d = ALLOCATE;
          end
        end
        ALLOCATE: begin
          cpu_stall_o  = 1'b1;
          mem_enable_o = 1'b1;
          mem_addr_o   = {miss_tag_q, miss_idx_q, {(OFF_W+2){1'b0}}};
          if (mem_ack_i) begin
            state_d = REFILL;
          end
        end
        REFILL: begin
          cpu_stall_o = 1'b1;
          state_d     = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - self-checking bench for dcache_ctrl
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [31:0]  cpu_addr_i = '0;
  logic [31:0]  cpu_data_i = '0;
  logic         cpu_MemRd_i = 1'b0;
  logic         cpu_MemWr_i = 1'b0;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;

  dcache_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_data_i   (cpu_data_i),
    .cpu_MemRd_i  (cpu_MemRd_i),
    .cpu_MemWr_i  (cpu_MemWr_i),
    .cpu_data_o   (cpu_data_o),
    .cpu_stall_o  (cpu_stall_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Backing memory: 128 lines covering byte addresses below 0x1000.
  logic [255:0] mem_m [128];
  // Architectural view: what every word should read as, regardless of where it lives.
  logic [31:0]  sh [1024];
  // Which memory line each cache slot holds, and whether it has unsaved stores.
  bit           mv   [32];
  bit           md   [32];
  logic [21:0]  mtag [32];

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } txn_t;
  txn_t log_q[$];

  int ack_delay = 0;
  bit mem_auto  = 1'b1;
  bit own_ack   = 1'b0;
  int wcnt      = 0;

  // Memory responder: acks ack_delay+1 cycles after it sees enable, logs each transfer.
  always @(negedge clk_i) begin
    txn_t t;
    if (own_ack) begin
      mem_ack_i = 1'b0;
      own_ack   = 1'b0;
      wcnt      = 0;
    end else if (mem_auto && mem_enable_o) begin
      if (wcnt >= ack_delay) begin
        t.wr   = mem_write_o;
        t.addr = mem_addr_o;
        t.data = mem_data_o;
        log_q.push_back(t);
        if (mem_write_o) mem_m[mem_addr_o[11:5]] = mem_data_o;
        else             mem_data_i = mem_m[mem_addr_o[11:5]];
        mem_ack_i = 1'b1;
        own_ack   = 1'b1;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic chk(input bit ok, input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic init_mem(input bit rnd);
    for (int l = 0; l < 128; l++) begin
      for (int w = 0; w < 8; w++) begin
        logic [31:0] v;
        v = rnd ? $urandom : ((l << 12) | 32'h100 | w);
        mem_m[l][32*w +: 32] = v;
        sh[l*8 + w] = v;
      end
    end
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    cpu_MemRd_i = 1'b0;
    cpu_MemWr_i = 1'b0;
    @(negedge clk_i);
    chk(cpu_stall_o == 1'b0,  {nm, " stall"},    cpu_stall_o,  0);
    chk(mem_enable_o == 1'b0, {nm, " enable"},   mem_enable_o, 0);
    chk(mem_write_o == 1'b0,  {nm, " write"},    mem_write_o,  0);
    chk(cpu_data_o == 32'h0,  {nm, " data"},     cpu_data_o,   0);
    chk(mem_addr_o == 32'h0,  {nm, " mem_addr"}, mem_addr_o,   0);
    chk(mem_data_o == '0,     {nm, " mem_data"}, mem_data_o,   0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    for (int i = 0; i < 32; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk_i); #1;
    cpu_MemRd_i = 1'b0;
    cpu_MemWr_i = 1'b0;
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    return mv[a[9:5]] && (mtag[a[9:5]] == a[31:10]);
  endfunction

  function automatic bit model_dirty_victim(input logic [31:0] a);
    return !model_hit(a) && mv[a[9:5]] && md[a[9:5]];
  endfunction

  // One CPU access held until the cache releases the stall, then checked against the model.
  task automatic do_op(input logic [31:0] a, input bit rd, input bit wr, input logic [31:0] wd,
                       input int exp_stall, input logic [31:0] exp_data, input string nm);
    int           idx;
    bit           hit;
    bit           wb;
    int           stalls;
    bit           done;
    bit           stable;
    bit           seen;
    bit           seen_wr;
    logic [31:0]  seen_addr;
    logic [255:0] seen_data;
    logic [31:0]  vaddr;
    logic [255:0] vline;
    int           nexp;
    idx   = a[9:5];
    hit   = model_hit(a);
    wb    = model_dirty_victim(a);
    vaddr = {mtag[idx], a[9:5], 5'b0};
    for (int w = 0; w < 8; w++) vline[32*w +: 32] = sh[vaddr[11:2] + w];
    log_q.delete();
    @(posedge clk_i); #1;
    cpu_addr_i  = a;
    cpu_data_i  = wd;
    cpu_MemRd_i = rd;
    cpu_MemWr_i = wr;
    stalls = 0;
    done   = 1'b0;
    stable = 1'b1;
    seen   = 1'b0;
    while (!done) begin
      @(negedge clk_i);
      if (!cpu_stall_o) begin
        done = 1'b1;
      end else begin
        stalls++;
        if (mem_enable_o) begin
          if (seen && seen_wr == mem_write_o &&
              (seen_addr != mem_addr_o || seen_data != mem_data_o)) stable = 1'b0;
          seen      = 1'b1;
          seen_wr   = mem_write_o;
          seen_addr = mem_addr_o;
          seen_data = mem_data_o;
        end
        if (stalls > 200) begin
          chk(1'b0, {nm, " stall timeout"}, stalls, exp_stall);
          done = 1'b1;
        end
      end
    end
    chk(stalls == exp_stall, {nm, " stall cycles"}, stalls, exp_stall);
    if (rd && !wr) chk(cpu_data_o == exp_data, {nm, " load data"}, cpu_data_o, exp_data);
    chk(stable, {nm, " mem outputs stable"}, stable, 1);
    nexp = hit ? 0 : (wb ? 2 : 1);
    chk(log_q.size() == nexp, {nm, " transfer count"}, log_q.size(), nexp);
    if (log_q.size() == nexp && nexp > 0) begin
      if (wb) begin
        chk(log_q[0].wr && log_q[0].addr == vaddr, {nm, " writeback addr"}, log_q[0].addr, vaddr);
        chk(log_q[0].data == vline, {nm, " writeback line"}, log_q[0].data, vline);
      end
      chk(!log_q[nexp-1].wr && log_q[nexp-1].addr == {a[31:5], 5'b0},
          {nm, " refill addr"}, log_q[nexp-1].addr, {a[31:5], 5'b0});
    end
    if (wr) sh[a[11:2]] = wd;
    md[idx]   = hit ? (md[idx] | wr) : wr;
    mv[idx]   = 1'b1;
    mtag[idx] = a[31:10];
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          rd;
    bit          wr;
    logic [31:0] wdata;
    int          stall;
    logic [31:0] data;
  } vec_t;
  vec_t tbl[8];

  initial begin
    tbl[0] = '{32'h010, 1, 0, 32'h0,         3, 32'h104};
    tbl[1] = '{32'h010, 1, 0, 32'h0,         0, 32'h104};
    tbl[2] = '{32'h014, 0, 1, 32'hDEADBEEF,  0, 32'h0};
    tbl[3] = '{32'h014, 1, 0, 32'h0,         0, 32'hDEADBEEF};
    tbl[4] = '{32'h414, 1, 0, 32'h0,         5, 32'h20105};
    tbl[5] = '{32'h820, 0, 1, 32'hCAFE0001,  3, 32'h0};
    tbl[6] = '{32'h820, 1, 0, 32'h0,         0, 32'hCAFE0001};
    tbl[7] = '{32'h020, 1, 0, 32'h0,         5, 32'h1100};

    init_mem(1'b0);
    do_reset("reset");

    ack_delay = 0;
    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].addr, tbl[i].rd, tbl[i].wr, tbl[i].wdata, tbl[i].stall, tbl[i].data,
            $sformatf("vec%0d", i));
    end

    // Slow memory: ack in the 10th ALLOCATE cycle, stall spans 12 cycles.
    ack_delay = 9;
    do_op(32'h060, 1, 0, 32'h0, 12, 32'h3100, "slow ack");
    ack_delay = 0;

    // Reset in the middle of ALLOCATE, then a stray ack.
    do_op(32'h414, 1, 0, 32'h0, 0, 32'h20105, "pre-reset hit");
    mem_auto = 1'b0;
    @(posedge clk_i); #1;
    cpu_addr_i  = 32'h0;
    cpu_MemRd_i = 1'b1;
    cpu_MemWr_i = 1'b0;
    @(negedge clk_i);
    chk(cpu_stall_o == 1'b1, "mid miss stall", cpu_stall_o, 1);
    @(negedge clk_i);
    chk(mem_enable_o == 1'b1 && mem_write_o == 1'b0, "mid allocate enable", {mem_enable_o, mem_write_o}, 2'b10);
    @(negedge clk_i);
    @(posedge clk_i); #1;
    rst_i       = 1'b1;
    cpu_MemRd_i = 1'b0;
    @(negedge clk_i);
    chk(mem_enable_o == 1'b0, "abort enable", mem_enable_o, 0);
    chk(cpu_stall_o == 1'b0,  "abort stall",  cpu_stall_o,  0);
    chk(mem_addr_o == 32'h0,  "abort addr",   mem_addr_o,   0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    for (int i = 0; i < 32; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    chk(mem_enable_o == 1'b0 && cpu_stall_o == 1'b0, "stray ack idle", {mem_enable_o, cpu_stall_o}, 0);
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    chk(mem_enable_o == 1'b0, "after stray ack", mem_enable_o, 0);
    mem_auto = 1'b1;
    do_op(32'h414, 1, 0, 32'h0, 3, 32'h20105, "post-reset miss");
    idle_cycle();

    // Randomized traffic against the architectural model.
    init_mem(1'b1);
    do_reset("reset2");
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int          mode;
      bit          rd;
      bit          wr;
      int          es;
      a = {20'h0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      mode = $urandom_range(0, 9);
      rd = (mode < 5) || (mode == 9);
      wr = (mode >= 5);
      ack_delay = $urandom_range(0, 3);
      if (model_hit(a))               es = 0;
      else if (model_dirty_victim(a)) es = 2 * ack_delay + 5;
      else                            es = ack_delay + 3;
      do_op(a, rd, wr, $urandom, es, sh[a[11:2]], $sformatf("rnd%0d", n));
    end
    idle_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
